// File: rtl/lock_gate.sv
// lock_gate: canal lock gate controller with travel timing, dwell hold, obstruction reversal and request refusal
module lock_gate #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic openReq,
    input  logic levelMatch,
    input  logic obstruct,
    output logic gateClosed,
    output logic gateOpen,
    output logic moving,
    output logic reject
);
    localparam int MAXC = (TRAVEL_CYCLES > HOLD_CYCLES) ? TRAVEL_CYCLES : HOLD_CYCLES;
    localparam int W    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [W-1:0] TRAVEL_LOAD = W'(TRAVEL_CYCLES - 1);
    localparam logic [W-1:0] HOLD_LOAD   = W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

    state_t       state;
    logic [W-1:0] count;

    assign gateClosed = (state == CLOSED);
    assign gateOpen   = (state == OPEN);
    assign moving     = (state == OPENING) || (state == CLOSING);

    // gate sequencing: level loss aborts opening, obstruction reverses closing, requests extend the dwell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CLOSED;
            count  <= '0;
            reject <= 1'b0;
        end else begin
            reject <= 1'b0;
            unique case (state)
                CLOSED: begin
                    if (openReq && levelMatch) begin
                        state <= OPENING;
                        count <= TRAVEL_LOAD;
                    end else if (openReq) begin
                        reject <= 1'b1;
                    end
                end
                OPENING: begin
                    if (!levelMatch) begin
                        state <= CLOSING;
                        count <= TRAVEL_LOAD;
                    end else if (count == '0) begin
                        state <= OPEN;
                        count <= HOLD_LOAD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                OPEN: begin
                    if (openReq) begin
                        count <= HOLD_LOAD;
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                    end else if (!obstruct) begin
                        state <= CLOSING;
                        count <= TRAVEL_LOAD;
                    end
                end
                CLOSING: begin
                    if (obstruct) begin
                        state <= OPENING;
                        count <= TRAVEL_LOAD;
                    end else if (count == '0) begin
                        state <= CLOSED;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= CLOSED;
                    count <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lock_gate.sv
// tb_lock_gate: directed checks of lock_gate timing, refusal, reversal, extension and reset
module tb_lock_gate;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic openReq = 1'b0;
    logic levelMatch = 1'b1;
    logic obstruct = 1'b0;
    logic gateClosed, gateOpen, moving, reject;
    int total = 0;
    int bad = 0;

    localparam logic [3:0] C = 4'b1000;
    localparam logic [3:0] O = 4'b0100;
    localparam logic [3:0] M = 4'b0010;
    localparam logic [3:0] R = 4'b1001;

    lock_gate #(.TRAVEL_CYCLES(4), .HOLD_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .openReq(openReq),
        .levelMatch(levelMatch),
        .obstruct(obstruct),
        .gateClosed(gateClosed),
        .gateOpen(gateOpen),
        .moving(moving),
        .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] got;
        got = {gateClosed, gateOpen, moving, reject};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got={closed,open,moving,reject}=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_for(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) begin
            chk(tag, exp);
            tick();
        end
    endtask

    task automatic accept();
        openReq = 1'b1;
        levelMatch = 1'b1;
        tick();
        openReq = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_async", C);
        tick();
        chk("reset_held", C);
        reset = 1'b0;
        expect_for("idle", 2, C);

        accept();
        expect_for("nom_opening", 4, M);
        expect_for("nom_open", 8, O);
        expect_for("nom_closing", 4, M);
        chk("nom_closed", C);

        levelMatch = 1'b0;
        openReq = 1'b1;
        repeat (3) begin
            tick();
            chk("reject_pulse", R);
        end
        openReq = 1'b0;
        tick();
        chk("reject_end", C);
        levelMatch = 1'b1;

        accept();
        expect_for("rev_opening", 4, M);
        expect_for("rev_open", 8, O);
        chk("rev_closing1", M);
        tick();
        obstruct = 1'b1;
        chk("rev_closing2", M);
        tick();
        obstruct = 1'b0;
        expect_for("rev_reopening", 4, M);
        expect_for("rev_fresh_dwell", 8, O);
        expect_for("rev_closing", 4, M);
        chk("rev_closed", C);

        accept();
        expect_for("obs_opening", 4, M);
        expect_for("obs_open", 7, O);
        obstruct = 1'b1;
        expect_for("obs_hold", 5, O);
        obstruct = 1'b0;
        chk("obs_release", O);
        tick();
        expect_for("obs_closing", 4, M);
        chk("obs_closed", C);

        accept();
        expect_for("ext_opening", 4, M);
        expect_for("ext_open_pre", 5, O);
        openReq = 1'b1;
        chk("ext_open6", O);
        tick();
        openReq = 1'b0;
        expect_for("ext_open_post", 8, O);
        openReq = 1'b1;
        expect_for("ext_closing_ignores_req", 4, M);
        openReq = 1'b0;
        chk("ext_closed", C);

        accept();
        levelMatch = 1'b0;
        expect_for("abort_travel", 5, M);
        chk("abort_closed", C);
        levelMatch = 1'b1;

        accept();
        tick();
        chk("mid_opening", M);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_travel", C);
        tick();
        chk("reset_mid_held", C);
        reset = 1'b0;
        expect_for("post_reset_idle", 5, C);
        accept();
        chk("post_reset_accept", M);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lock_gate.md
LOCK_GATE -- requirements
Module: lock_gate

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 4, is the gate travel time in clock cycles (legal range >= 1).
REQ-002 Parameter HOLD_CYCLES, default 8, is the minimum open dwell time in clock cycles (legal range >= 1).
REQ-003 Port clk, input, 1, is the single clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1, is the asynchronous, active-high reset.
REQ-005 Port openReq, input, 1, is the request to open the gate, sampled each posedge.
REQ-006 Port levelMatch, input, 1, is high when water levels on both sides of the gate are equal.
REQ-007 Port obstruct, input, 1, is high when a gondola is in the gate opening.
REQ-008 Port gateClosed, output, 1, is high when the gate is fully closed.
REQ-009 Port gateOpen, output, 1, is high when the gate is fully open.
REQ-010 Port moving, output, 1, is high while the gate is opening or closing.
REQ-011 Port reject, output, 1, is a one-cycle pulse when an open request is refused.

Function
REQ-012 The FSM SHALL have four states: CLOSED, OPENING, OPEN, CLOSING.
REQ-013 The internal down-counter SHALL be wide enough to hold max(TRAVEL_CYCLES, HOLD_CYCLES)-1.
REQ-014 gateClosed SHALL equal (state==CLOSED), gateOpen (state==OPEN), and moving (state==OPENING or CLOSING); these are Moore outputs.
REQ-015 In CLOSED with openReq=1 and levelMatch=1, the FSM SHALL go to OPENING and load count=TRAVEL_CYCLES-1.
REQ-016 In CLOSED with openReq=1 and levelMatch=0, the FSM SHALL stay CLOSED and assert reject for exactly the next cycle (registered).
REQ-017 reject SHALL be 0 in every other case; a held refused request SHALL pulse reject every cycle it is sampled.
REQ-018 In OPENING, the counter SHALL decrement while nonzero; at count==0 the FSM SHALL go to OPEN and load count=HOLD_CYCLES-1, so OPENING lasts exactly TRAVEL_CYCLES cycles.
REQ-019 In OPENING with levelMatch=0, the FSM SHALL abort to CLOSING and load count=TRAVEL_CYCLES-1; this takes priority over completion.
REQ-020 In OPEN with openReq=1, the FSM SHALL reload count=HOLD_CYCLES-1 and stay OPEN (dwell extension).
REQ-021 In OPEN at count==0 with openReq=0, the FSM SHALL go to CLOSING (count=TRAVEL_CYCLES-1) if obstruct=0, else stay OPEN with count held at 0.
REQ-022 In CLOSING with obstruct=1, the FSM SHALL reverse to OPENING and load count=TRAVEL_CYCLES-1; this takes priority over completion.
REQ-023 In CLOSING at count==0 with obstruct=0, the FSM SHALL go to CLOSED.
REQ-024 openReq SHALL be ignored in OPENING and CLOSING.
REQ-025 Nominal latency: an accepted request sampled at edge N gives OPENING from N+1, OPEN from N+1+TRAVEL_CYCLES, and CLOSED after a further HOLD_CYCLES+TRAVEL_CYCLES cycles.

Reset
REQ-026 While reset=1, the FSM SHALL be CLOSED with count=0 and reject=0, so gateClosed=1, gateOpen=0 and moving=0, independent of clk.
REQ-027 Reset asserted in any state, including mid-travel, SHALL force CLOSED immediately; the first transition after release requires a new openReq.

Verification (TRAVEL_CYCLES=4, HOLD_CYCLES=8)
REQ-028 Reset pulse mid-OPENING -> gateClosed=1 asynchronously; no motion after release without openReq.
REQ-029 openReq=1 for 1 cycle with levelMatch=1 -> moving=1 for 4 cycles, gateOpen=1 for 8 cycles, moving=1 for 4 cycles, then gateClosed=1; reject stays 0.
REQ-030 openReq=1 with levelMatch=0 for 3 cycles in CLOSED -> reject=1 for 3 consecutive cycles; gateClosed stays 1.
REQ-031 obstruct=1 during the 2nd CLOSING cycle -> OPENING next cycle, then 4 cycles later OPEN with a fresh 8-cycle dwell.
REQ-032 obstruct held high at OPEN count==0 -> gateOpen stays 1 until obstruct=0, then CLOSING on the next edge.
REQ-033 openReq pulsed at the 6th OPEN cycle -> OPEN extends to 14 cycles total; levelMatch=0 in OPENING -> CLOSING next cycle.
